// File: rtl/demux32_8_unpacker.sv
// Word-to-byte unpacker: takes 32-bit words and streams each one out as four
// consecutive bytes. A one-word pending buffer lets the next word be accepted
// while the current one is still shifting out, so back-to-back words stream
// without gaps.
module demux32_8_unpacker #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [7:0]  data_out,
    output logic        valid_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n;              // index of the byte currently on data_out
    logic [31:0] shift_reg, shift_reg_n;  // bytes of the current word not yet emitted
    logic [31:0] pend_reg, pend_reg_n;
    logic        pend_full, pend_full_n;
    logic [7:0]  data_out_n;
    logic        valid_out_n;

    logic        accept;
    logic        do_load;
    logic [31:0] load_word;

    // Leading byte of a word in the configured byte order.
    function automatic logic [7:0] lead_byte(input logic [31:0] w);
        return MSB_FIRST ? w[31:24] : w[7:0];
    endfunction

    // Word with its leading byte removed, remaining bytes moved up to the lead slot.
    function automatic logic [31:0] drop_byte(input logic [31:0] w);
        return MSB_FIRST ? {w[23:0], 8'h00} : {8'h00, w[31:8]};
    endfunction

    // The pending buffer being occupied is the only source of backpressure.
    assign ready_out = !reset && !pend_full;
    assign accept    = valid_in && ready_out;

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_n     = state;
        cnt_n       = cnt;
        shift_reg_n = shift_reg;
        pend_reg_n  = pend_reg;
        pend_full_n = pend_full;
        data_out_n  = 8'h00;
        valid_out_n = 1'b0;
        do_load     = 1'b0;
        load_word   = data_in;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    do_load   = 1'b1;
                    load_word = data_in;
                end
            end
            SHIFT: begin
                if (cnt != 2'd3) begin
                    data_out_n  = lead_byte(shift_reg);
                    valid_out_n = 1'b1;
                    shift_reg_n = drop_byte(shift_reg);
                    cnt_n       = cnt + 2'd1;
                    if (accept) begin
                        pend_reg_n  = data_in;
                        pend_full_n = 1'b1;
                    end
                end else if (pend_full) begin
                    // Drain the pending word; ready_out is low so nothing is accepted.
                    do_load     = 1'b1;
                    load_word   = pend_reg;
                    pend_full_n = 1'b0;
                end else if (accept) begin
                    do_load   = 1'b1;
                    load_word = data_in;
                end else begin
                    state_n = IDLE;
                    cnt_n   = 2'd0;
                end
            end
            default: state_n = IDLE;
        endcase

        // A load emits byte 0 immediately and keeps the remaining three.
        if (do_load) begin
            state_n     = SHIFT;
            cnt_n       = 2'd0;
            data_out_n  = lead_byte(load_word);
            valid_out_n = 1'b1;
            shift_reg_n = drop_byte(load_word);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_4f) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            shift_reg <= 32'h0;
            pend_reg  <= 32'h0;
            pend_full <= 1'b0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shift_reg <= shift_reg_n;
            pend_reg  <= pend_reg_n;
            pend_full <= pend_full_n;
            data_out  <= data_out_n;
            valid_out <= valid_out_n;
        end
    end

endmodule

// File: tb/tb_demux32_8_unpacker.sv
// Directed bench for demux32_8_unpacker: reset, single word, back-to-back
// streaming with backpressure, idle input, mid-word reset, LSB-first order.
module tb_demux32_8_unpacker;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out, ready_lsb;
    logic [7:0]  data_out, data_lsb;
    logic        valid_out, valid_lsb;

    int n_assert = 0;
    int n_fail   = 0;

    demux32_8_unpacker #(.MSB_FIRST(1'b1)) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    demux32_8_unpacker #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_lsb),
        .data_out  (data_lsb),
        .valid_out (valid_lsb)
    );

    always #5 clk_4f = ~clk_4f;

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v);
        chk({tag, " data"}, {24'h0, data_out}, {24'h0, d});
        chk({tag, " valid"}, {31'h0, valid_out}, {31'h0, v});
    endtask

    logic [31:0] words  [3]  = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    logic [7:0]  exp_b  [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                                 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    logic        exp_rdy[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0]  exp_de [4]  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    initial begin
        int  idx;
        logic acc;

        // Reset held for 4 edges.
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 32'h0;
        #1;
        for (int i = 0; i < 4; i++) tick();
        chk_out("reset", 8'h00, 1'b0);
        chk("reset ready", {31'h0, ready_out}, 32'h0);
        reset = 1'b0;
        tick();
        chk("ready after release", {31'h0, ready_out}, 32'h1);

        // Single word, MSB first.
        data_in  = 32'hDEADBEEF;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        data_in  = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("single byte%0d", i), exp_de[i], 1'b1);
            tick();
        end
        chk_out("single done", 8'h00, 1'b0);
        tick();
        chk_out("single idle", 8'h00, 1'b0);

        // Back-to-back words with valid_in held high while words remain.
        idx      = 0;
        valid_in = 1'b1;
        data_in  = words[0];
        for (int k = 0; k < 12; k++) begin
            acc = valid_in && ready_out;
            tick();
            if (acc) idx++;
            valid_in = (idx < 3);
            data_in  = (idx < 3) ? words[idx] : $urandom();
            chk_out($sformatf("stream byte%0d", k), exp_b[k], 1'b1);
            chk($sformatf("stream ready%0d", k), {31'h0, ready_out}, {31'h0, exp_rdy[k]});
        end
        chk("stream words accepted", idx, 32'd3);
        valid_in = 1'b0;
        tick();
        chk_out("stream done", 8'h00, 1'b0);

        // valid_in low with data changing: nothing produced.
        for (int i = 0; i < 16; i++) begin
            data_in = $urandom();
            tick();
            chk("idle valid", {31'h0, valid_out}, 32'h0);
        end

        // Reset after two bytes, with a word pending.
        data_in  = 32'hCAFEF00D;
        valid_in = 1'b1;
        tick();
        chk_out("midrst byte0", 8'hCA, 1'b1);
        data_in = 32'h01020304;
        tick();
        valid_in = 1'b0;
        chk_out("midrst byte1", 8'hFE, 1'b1);
        reset = 1'b1;
        tick();
        chk_out("midrst reset", 8'h00, 1'b0);
        chk("midrst ready", {31'h0, ready_out}, 32'h0);
        reset    = 1'b0;
        data_in  = 32'hA5A5A5A5;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("fresh byte%0d", i), 8'hA5, 1'b1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("fresh after%0d", i), 8'h00, 1'b0);
            tick();
        end

        // LSB-first instance.
        data_in  = 32'hDEADBEEF;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lsb data%0d", i), {24'h0, data_lsb}, {24'h0, exp_de[3-i]});
            chk($sformatf("lsb valid%0d", i), {31'h0, valid_lsb}, 32'h1);
            tick();
        end
        chk("lsb done valid", {31'h0, valid_lsb}, 32'h0);
        chk("lsb done data", {24'h0, data_lsb}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
